// File: rtl/sb_arb_pkg.sv
// rtl/sb_arb_pkg.sv - shared types and default widths for the switchboard round-robin arbiter
package sb_arb_pkg;

  // IDLE: picking the next packet round-robin; LOCKED: forwarding the rest of one packet
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int SB_DW    = 256;
  localparam int SB_DESTW = 32;

endpackage

// File: rtl/sb_rr_pick.sv
// rtl/sb_rr_pick.sv - combinational round-robin picker starting one past ptr
module sb_rr_pick
  import sb_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  // scan ptr+1, ptr+2, ... wrapping, and take the first requester
  always_comb begin
    int cand;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/sb_rr_arbiter.sv
// rtl/sb_rr_arbiter.sv - packet-atomic round-robin merge of NUM_PORTS streams into one registered output
module sb_rr_arbiter
  import sb_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DW        = SB_DW,
  parameter int DESTW     = SB_DESTW,
  localparam int SW       = $clog2(NUM_PORTS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS*DW-1:0]    in_data,
  input  logic [NUM_PORTS*DESTW-1:0] in_dest,
  input  logic [NUM_PORTS-1:0]       in_last,
  input  logic [NUM_PORTS-1:0]       in_valid,
  output logic [NUM_PORTS-1:0]       in_ready,
  output logic [DW-1:0]              out_data,
  output logic [DESTW-1:0]           out_dest,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SW-1:0]              out_src
);

  arb_state_e           state;
  logic [SW-1:0]        ptr;
  logic [SW-1:0]        gnt;
  logic                 can_accept;
  logic [NUM_PORTS-1:0] pick_oh;
  logic [NUM_PORTS-1:0] lock_oh;
  logic [SW-1:0]        pick_idx;
  logic                 pick_found;
  logic [SW-1:0]        sel_idx;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 xfer;
  logic [DW-1:0]        sel_data;
  logic [DESTW-1:0]     sel_dest;

  // the output stage can take a new beat when empty or draining this cycle
  assign can_accept = !out_valid || out_ready;

  sb_rr_pick #(
    .N  (NUM_PORTS),
    .IW (SW)
  ) u_pick (
    .req   (in_valid),
    .ptr   (ptr),
    .gnt   (pick_oh),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // choose the serving port: the locked owner, or the round-robin pick when idle
  always_comb begin
    lock_oh      = '0;
    lock_oh[gnt] = 1'b1;
    if (state == ST_LOCKED) begin
      sel_idx   = gnt;
      sel_valid = in_valid[gnt];
    end else begin
      sel_idx   = pick_idx;
      sel_valid = pick_found;
    end
    sel_last = in_last[sel_idx];
    xfer     = !rst && sel_valid && can_accept;
    if (rst || !can_accept) begin
      in_ready = '0;
    end else if (state == ST_LOCKED) begin
      in_ready = lock_oh;
    end else begin
      in_ready = pick_oh;
    end
  end

  assign sel_data = in_data[int'(sel_idx)*DW +: DW];
  assign sel_dest = in_dest[int'(sel_idx)*DESTW +: DESTW];

  // packet lock: a first beat without last locks the port; any last beat unlocks and moves ptr
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= SW'(NUM_PORTS - 1);
      gnt   <= '0;
    end else if (xfer) begin
      if (sel_last) begin
        state <= ST_IDLE;
        ptr   <= sel_idx;
      end else begin
        state <= ST_LOCKED;
        gnt   <= sel_idx;
      end
    end
  end

  // single output register: load on transfer, drop valid once consumed with nothing new behind it
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_dest  <= '0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_last  <= sel_last;
      out_data  <= sel_data;
      out_dest  <= sel_dest;
      out_src   <= sel_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sb_rr_arbiter.sv
// tb/tb_sb_rr_arbiter.sv - scoreboard bench for sb_rr_arbiter with a queue-based arbitration model
module tb_sb_rr_arbiter;

  localparam int N      = 4;
  localparam int DW     = 256;
  localparam int DESTW  = 32;
  localparam int SW     = 2;
  localparam int M_DIR  = 0;
  localparam int M_RAND = 1;
  localparam int M_DRN  = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N*DW-1:0]      in_data  = '0;
  logic [N*DESTW-1:0]   in_dest  = '0;
  logic [N-1:0]         in_last  = '0;
  logic [N-1:0]         in_valid = '0;
  logic [N-1:0]         in_ready;
  logic [DW-1:0]        out_data;
  logic [DESTW-1:0]     out_dest;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [SW-1:0]        out_src;

  sb_rr_arbiter #(
    .NUM_PORTS (N),
    .DW        (DW),
    .DESTW     (DESTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_dest  (out_dest),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]    data;
    logic [DESTW-1:0] dest;
    logic             last;
    int               src;
  } beat_t;

  int    tests = 0;
  int    fails = 0;
  beat_t exp_q[$];
  beat_t e;
  int    src_log[$];
  int    cyc_log[$];
  int    cyc = 0;
  int    n_beats = 0;

  logic [DW-1:0]    p_data[N];
  logic [DESTW-1:0] p_dest[N];
  logic             p_last[N];
  bit               p_pend[N];
  int               p_beat[N];
  int               p_len[N];
  int               p_seq[N];
  int               dir_pkts[N];
  int               dir_len[N];
  int               wcnt[N];
  int               max_wait = 0;

  int mode       = M_DIR;
  bit want_ready = 1'b1;
  bit want_rst   = 1'b1;
  int m_owner    = -1;
  int m_ptr      = N - 1;
  bit m_ov       = 1'b0;

  task automatic check(input bit ok, input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic gen_beat(input int p);
    for (int i = 0; i < DW / 32; i++) p_data[p][i*32 +: 32] = $urandom;
    p_data[p][DW-1 -: 8]  = 8'(p);
    p_data[p][DW-9 -: 16] = 16'(p_seq[p]);
    p_seq[p]++;
    p_dest[p] = $urandom;
    p_last[p] = (p_beat[p] + 1 == p_len[p]);
  endtask

  task automatic new_packet(input int p, input int len);
    p_len[p]  = len;
    p_beat[p] = 0;
    gen_beat(p);
  endtask

  task automatic setup_dir(input int p, input int pkts, input int len);
    dir_pkts[p] = pkts;
    dir_len[p]  = len;
    new_packet(p, len);
    p_pend[p] = 1'b1;
  endtask

  // a port's beat has been taken: move its generator to the next beat or packet
  task automatic advance(input int p);
    p_beat[p]++;
    if (p_beat[p] == p_len[p]) begin
      if (mode == M_RAND) begin
        new_packet(p, 1 + int'($urandom % 4));
        p_pend[p] = 1'b0;
      end else if (mode == M_DIR && dir_pkts[p] > 1) begin
        dir_pkts[p]--;
        new_packet(p, dir_len[p]);
        p_pend[p] = 1'b1;
      end else begin
        dir_pkts[p] = 0;
        new_packet(p, 1);
        p_pend[p] = 1'b0;
      end
    end else begin
      gen_beat(p);
      p_pend[p] = (mode != M_RAND);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      in_valid[p]                  = p_pend[p];
      in_last[p]                   = p_last[p];
      in_data[p*DW +: DW]          = p_data[p];
      in_dest[p*DESTW +: DESTW]    = p_dest[p];
    end
  endtask

  // reference: who may send this cycle, from owner / last-served port / pending flags
  task automatic model_cycle();
    logic [N-1:0] exp_rdy;
    int src;
    bit ca;
    bit xf;
    exp_rdy = '0;
    src     = -1;
    xf      = 1'b0;
    if (!rst) begin
      ca = !m_ov || out_ready;
      if (m_owner >= 0) begin
        src = m_owner;
      end else begin
        for (int k = 1; k <= N; k++) begin
          int q;
          q = (m_ptr + k) % N;
          if (src < 0 && p_pend[q]) src = q;
        end
      end
      if (src >= 0 && ca) exp_rdy[src] = 1'b1;
      xf = (src >= 0) && ca && p_pend[src];
    end
    check(in_ready === exp_rdy, "in_ready", in_ready, exp_rdy);
    if (rst) begin
      m_owner = -1;
      m_ptr   = N - 1;
      m_ov    = 1'b0;
      exp_q.delete();
      for (int p = 0; p < N; p++) begin
        p_pend[p]   = 1'b0;
        dir_pkts[p] = 0;
        new_packet(p, 1);
      end
      return;
    end
    if (xf) begin
      exp_q.push_back('{data: p_data[src], dest: p_dest[src], last: p_last[src], src: src});
      if (p_last[src]) begin
        m_ptr   = src;
        m_owner = -1;
      end else begin
        m_owner = src;
      end
      advance(src);
    end
    m_ov = xf ? 1'b1 : (out_ready ? 1'b0 : m_ov);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rst       = want_rst;
    out_ready = want_ready;
    if (mode == M_RAND) begin
      out_ready = ($urandom % 4) != 0;
      for (int p = 0; p < N; p++) if (!p_pend[p]) p_pend[p] = ($urandom % 3) != 0;
    end else if (mode == M_DRN) begin
      for (int p = 0; p < N; p++) if (!p_pend[p] && p_beat[p] > 0) p_pend[p] = 1'b1;
    end
    drive();
    #1;
    model_cycle();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    src_log.delete();
    cyc_log.delete();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0]    hold_data;
  logic [DESTW-1:0] hold_dest;
  logic             hold_last;
  logic [SW-1:0]    hold_src;
  bit               stalled   = 1'b0;
  bit               prev_open = 1'b0;
  int               prev_src  = 0;

  // monitor: pop the expected beat whenever the merged stream hands one downstream
  always @(negedge clk) begin
    if (rst) begin
      stalled   = 1'b0;
      prev_open = 1'b0;
      for (int p = 0; p < N; p++) wcnt[p] = 0;
    end else begin
      if (stalled)
        check(out_valid === 1'b1 && out_data === hold_data && out_dest === hold_dest &&
              out_last === hold_last && out_src === hold_src, "stall_hold", out_data, hold_data);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_beat", out_src, 0);
        end else begin
          e = exp_q.pop_front();
          check(out_data === e.data, "sb_data", out_data, e.data);
          check(out_dest === e.dest, "sb_dest", out_dest, e.dest);
          check(out_last === e.last, "sb_last", out_last, e.last);
          check(int'(out_src) == e.src, "sb_src", out_src, e.src);
        end
        if (prev_open) check(int'(out_src) == prev_src, "no_interleave", out_src, prev_src);
        prev_open = !out_last;
        prev_src  = int'(out_src);
        src_log.push_back(int'(out_src));
        cyc_log.push_back(cyc);
      end
      stalled   = (out_valid === 1'b1) && (out_ready === 1'b0);
      hold_data = out_data;
      hold_dest = out_dest;
      hold_last = out_last;
      hold_src  = out_src;
      for (int q = 0; q < N; q++) begin
        if (in_valid[q] && in_ready[q] && in_last[q]) begin
          for (int p = 0; p < N; p++)
            if (p != q && in_valid[p] && p_beat[p] == 0) wcnt[p]++;
        end
      end
      for (int q = 0; q < N; q++) begin
        if (in_valid[q] && in_ready[q]) wcnt[q] = 0;
        if (wcnt[q] > max_wait) max_wait = wcnt[q];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_a[4];
    logic [DW-1:0] d0;
    logic [DW-1:0] aa;
    int n;

    for (int p = 0; p < N; p++) begin
      p_seq[p]    = 0;
      p_pend[p]   = 1'b0;
      dir_pkts[p] = 0;
      wcnt[p]     = 0;
      new_packet(p, 1);
    end

    // reset values
    want_rst = 1'b1;
    run(2);
    want_rst = 1'b0;
    step();
    check(out_valid === 1'b0, "rst_out_valid", out_valid, 0);
    check(out_last === 1'b0, "rst_out_last", out_last, 0);
    check(out_data === '0, "rst_out_data", out_data, 0);
    check(out_dest === '0, "rst_out_dest", out_dest, 0);
    check(out_src === '0, "rst_out_src", out_src, 0);

    // two single-beat streams alternate at full rate, port 0 first
    clear_logs();
    setup_dir(0, 2, 1);
    setup_dir(2, 2, 1);
    run(6);
    exp_a = '{0, 2, 0, 2};
    check(src_log.size() == 4, "alt_count", src_log.size(), 4);
    if (src_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check(src_log[i] == exp_a[i], "alt_src", src_log[i], exp_a[i]);
        check(cyc_log[i] == cyc_log[0] + i, "alt_b2b", cyc_log[i] - cyc_log[0], i);
      end
    end

    // a 3-beat packet on port 1 holds off a waiting port 3
    want_rst = 1'b1;
    step();
    want_rst = 1'b0;
    clear_logs();
    setup_dir(1, 1, 3);
    setup_dir(3, 1, 1);
    for (int i = 0; i < 8; i++) begin
      bit locked;
      locked = (m_owner == 1);
      step();
      if (locked) check(in_ready[3] === 1'b0, "lock_blocks_p3", in_ready[3], 0);
    end
    exp_a = '{1, 1, 1, 3};
    check(src_log.size() == 4, "lock_count", src_log.size(), 4);
    if (src_log.size() == 4)
      for (int i = 0; i < 4; i++) check(src_log[i] == exp_a[i], "lock_src", src_log[i], exp_a[i]);

    // downstream stall for five cycles
    clear_logs();
    setup_dir(0, 3, 1);
    d0 = p_data[0];
    want_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check(out_valid === 1'b1, "stall_valid", out_valid, 1);
      check(in_ready === '0, "stall_ready", in_ready, 0);
      check(out_data === d0, "stall_data", out_data, d0);
    end
    want_ready = 1'b1;
    run(6);
    check(src_log.size() == 3, "stall_count", src_log.size(), 3);

    // fixed payload on port 2, visible one cycle after the transfer
    aa = {(DW / 8){8'hAA}};
    setup_dir(2, 1, 1);
    p_data[2] = aa;
    p_dest[2] = 32'd7;
    step();
    check(out_valid === 1'b0, "lat_before", out_valid, 0);
    step();
    check(out_valid === 1'b1, "lat_valid", out_valid, 1);
    check(out_data === aa, "lat_data", out_data, aa);
    check(out_dest === 32'd7, "lat_dest", out_dest, 7);
    check(out_src === 2'd2, "lat_src", out_src, 2);
    run(2);

    // reset in the middle of a 4-beat packet
    setup_dir(2, 1, 4);
    run(2);
    want_rst = 1'b1;
    step();
    want_rst = 1'b0;
    step();
    check(out_valid === 1'b0, "mid_rst_valid", out_valid, 0);
    clear_logs();
    for (int p = 0; p < N; p++) setup_dir(p, 1, 1);
    run(8);
    check(src_log.size() == 4, "resume_count", src_log.size(), 4);
    if (src_log.size() > 0) check(src_log[0] == 0, "resume_first", src_log[0], 0);

    // random traffic, then drain
    mode = M_RAND;
    run(10000);
    mode = M_DRN;
    want_ready = 1'b1;
    run(60);
    check(exp_q.size() == 0, "drain_empty", exp_q.size(), 0);
    n = 0;
    for (int p = 0; p < N; p++) n += int'(p_pend[p]);
    check(n == 0, "drain_idle", n, 0);
    check(max_wait <= N - 1, "starvation_bound", max_wait, N - 1);
    check(n_beats > 1000, "beats_seen", n_beats, 1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sb_rr_arbiter.md
SB_RR_ARBITER -- requirements
Module: sb_rr_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, is the number of switchboard input streams (2..16).
REQ-002 Parameter DW, default 256, is the data width per beat.
REQ-003 Parameter DESTW, default 32, is the dest width.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_data  input  NUM_PORTS*DW  per-port data; port i occupies bits [i*DW +: DW].
REQ-007 in_dest  input  NUM_PORTS*DESTW  per-port dest, packed the same way.
REQ-008 in_last  input  NUM_PORTS  per-port end-of-packet flag.
REQ-009 in_valid  input  NUM_PORTS  per-port beat valid.
REQ-010 in_ready  output  NUM_PORTS  per-port beat accept.
REQ-011 out_data, out_dest, out_last  output  DW, DESTW, 1  merged stream payload.
REQ-012 out_valid  output  1  merged beat valid.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 out_src  output  $clog2(NUM_PORTS)  index of the port that sourced the current out beat.

Function
REQ-015 A beat SHALL transfer on any port when valid and ready are both high in the same cycle; payload is sampled only on transfer.
REQ-016 Output SHALL be a single registered stage: a beat accepted at cycle t is presented on out_* at t+1; latency is one cycle.
REQ-017 can_accept = !out_valid || out_ready; at most one in_ready bit SHALL be high, and only when can_accept.
REQ-018 FSM states: IDLE and LOCKED (holding granted port index gnt).
REQ-019 In IDLE, grant SHALL be chosen combinationally as the first port with in_valid high, searching round-robin from ptr+1 modulo NUM_PORTS; that port's in_ready = can_accept.
REQ-020 If a beat transfers in IDLE with in_last=0: go to LOCKED with gnt = that port; if in_last=1: stay IDLE and set ptr = that port.
REQ-021 In LOCKED, only in_ready[gnt] = can_accept; other ports SHALL see in_ready=0 regardless of valid.
REQ-022 In LOCKED, a transfer with in_last=1 SHALL return to IDLE and set ptr = gnt; packets are never interleaved.
REQ-023 ptr SHALL change only when a last beat transfers; bubbles (in_valid low while LOCKED) hold the lock indefinitely.
REQ-024 Output register SHALL load data, dest, last, and src on input transfer; out_valid SHALL be set on input transfer, cleared when out_ready && no new transfer, and held otherwise.
REQ-025 Back-to-back: with out_ready held high, one beat per cycle SHALL pass (full throughput, including across packet boundaries).
REQ-026 With no valid inputs in IDLE, all in_ready SHALL be 0 and state, ptr, and the output register (except out_valid) SHALL be unchanged.
REQ-027 The out_* payload SHALL hold stable while out_valid && !out_ready.

Reset
REQ-028 On rst: state=IDLE, ptr=NUM_PORTS-1 (port 0 highest priority first), out_valid=0, out_last=0, out_data=0, out_dest=0, out_src=0; in_ready=0 during the rst cycle.
REQ-029 Reset mid-packet SHALL drop the lock and discard any buffered output beat; the partial packet is not completed.

Structure
REQ-030 Package sb_arb_pkg SHALL hold the FSM state enum and default width constants (DW, DESTW).
REQ-031 Sub-module sb_rr_pick SHALL implement the combinational round-robin picker (inputs: request vector and ptr; outputs: one-hot grant and index).

Verification
REQ-032 Reset, then ports 0 and 2 both valid with 1-beat packets, out_ready=1 -> out_src sequence 0,2,0,2 on consecutive cycles.
REQ-033 Port 1 sends a 3-beat packet while port 3 is valid throughout -> out_src=1,1,1 then 3, with no port-3 beat in between; in_ready[3]=0 during the lock.
REQ-034 out_ready=0 for 5 cycles with out_valid=1 -> out_data is stable, all in_ready=0, and no beat is lost or duplicated after out_ready=1.
REQ-035 Data 0xAA..AA/dest 7 on port 2 -> out_data=0xAA..AA, out_dest=7, out_src=2 exactly one cycle after transfer.
REQ-036 rst asserted after beat 2 of a 4-beat packet -> next cycle out_valid=0, state IDLE, and port 0 is granted first on resumption.
REQ-037 Random valid/last/out_ready on all 4 ports for 10k cycles -> scoreboard shows per-port order preserved, no interleaving, and starvation bound of NUM_PORTS-1 packets.
